// File: rtl/peak_detector_adaptive_if.sv
// Sample/result bundle for peak_detector_adaptive. The master drives samples and the slave
// (the detector) drives results.
interface peak_detector_adaptive_if #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned IBI_WIDTH = 12
);
  logic                    en;
  logic signed [WIDTH-1:0] ppg_in;
  logic                    valid_in;
  logic                    peak_valid;
  logic signed [WIDTH-1:0] peak_amp;
  logic [IBI_WIDTH-1:0]    ibi;
  logic                    ibi_valid;
  logic                    timeout;
  logic signed [WIDTH-1:0] thr_out;

  modport master (
    output en, ppg_in, valid_in,
    input  peak_valid, peak_amp, ibi, ibi_valid, timeout, thr_out
  );

  modport slave (
    input  en, ppg_in, valid_in,
    output peak_valid, peak_amp, ibi, ibi_valid, timeout, thr_out
  );
endinterface

// File: rtl/peak_detector_adaptive.sv
// Adaptive-threshold PPG peak detector with IBI measurement and loss-of-signal timeout.
// Optional macro PEAK_PLATEAU_EN accepts flat-topped peaks.
module peak_detector_adaptive #(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned MIN_THRESH   = 20,
  parameter int unsigned REF_PERIOD   = 8,
  parameter int unsigned DECAY_PERIOD = 16,
  parameter int unsigned DECAY_SHIFT  = 3,
  parameter int unsigned IBI_WIDTH    = 12,
  parameter int unsigned MAX_IBI      = 2047
) (
  input  logic                   clk,
  input  logic                   rst,
  peak_detector_adaptive_if.slave bus
);

  localparam int unsigned RefW = (REF_PERIOD > 0) ? $clog2(REF_PERIOD + 1) : 1;
  localparam int unsigned DecW = (DECAY_PERIOD > 0) ? $clog2(DECAY_PERIOD + 1) : 1;
  localparam logic signed [WIDTH-1:0] MinThr = WIDTH'(MIN_THRESH);
  localparam logic signed [WIDTH:0]   MinExt = (WIDTH+1)'(MIN_THRESH);
  localparam logic [IBI_WIDTH-1:0]    MaxIbi = IBI_WIDTH'(MAX_IBI);

  logic signed [WIDTH-1:0] prev_q, prev_d, prev2_q, prev2_d, thr_q, thr_d;
  logic signed [WIDTH-1:0] peak_amp_q, peak_amp_d;
  logic [RefW-1:0]         ref_cnt_q, ref_cnt_d;
  logic [IBI_WIDTH-1:0]    since_cnt_q, since_cnt_d, ibi_q, ibi_d, since_inc;
  logic [DecW-1:0]         decay_cnt_q, decay_cnt_d, decay_inc;
  logic                    have_prev_q, have_prev_d;
  logic                    peak_valid_q, peak_valid_d, ibi_valid_q, ibi_valid_d;
  logic                    timeout_q, timeout_d;
  logic                    strict_detect, plat_detect, detect;
  logic signed [WIDTH:0]   thr_ext, prev_ext, thr_peak, thr_dec;

  assign thr_ext   = {thr_q[WIDTH-1], thr_q};
  assign prev_ext  = {prev_q[WIDTH-1], prev_q};
  assign thr_peak  = (thr_ext >>> 1) + (prev_ext >>> 2);
  assign thr_dec   = thr_ext - (thr_ext >>> DECAY_SHIFT);
  assign since_inc = since_cnt_q + IBI_WIDTH'(1);
  assign decay_inc = decay_cnt_q + DecW'(1);

  assign strict_detect = (ref_cnt_q == '0) && (prev_q > prev2_q) && (prev_q > bus.ppg_in) &&
                         (prev_q > thr_q);

`ifdef PEAK_PLATEAU_EN
  // While the flag is set prev always holds the plateau value, so prev is the peak sample.
  logic plat_q, plat_d;

  assign plat_detect = plat_q && (ref_cnt_q == '0) && (bus.ppg_in < prev_q) && (prev_q > thr_q);
`else
  assign plat_detect = 1'b0;
`endif

  assign detect = strict_detect || plat_detect;

  always_comb begin
    prev_d       = prev_q;
    prev2_d      = prev2_q;
    thr_d        = thr_q;
    peak_amp_d   = peak_amp_q;
    ref_cnt_d    = ref_cnt_q;
    since_cnt_d  = since_cnt_q;
    ibi_d        = ibi_q;
    decay_cnt_d  = decay_cnt_q;
    have_prev_d  = have_prev_q;
    peak_valid_d = 1'b0;
    ibi_valid_d  = 1'b0;
    timeout_d    = 1'b0;
`ifdef PEAK_PLATEAU_EN
    plat_d       = plat_q;
`endif
    if (bus.en && bus.valid_in) begin
      prev2_d = prev_q;
      prev_d  = bus.ppg_in;
      if (detect) begin
        peak_valid_d = 1'b1;
        peak_amp_d   = prev_q;
        ref_cnt_d    = RefW'(REF_PERIOD);
        decay_cnt_d  = '0;
        since_cnt_d  = '0;
        have_prev_d  = 1'b1;
        if (have_prev_q) begin
          ibi_d       = since_inc;
          ibi_valid_d = 1'b1;
        end
        thr_d = (thr_peak > MinExt) ? thr_peak[WIDTH-1:0] : MinThr;
      end else begin
        if (ref_cnt_q != '0) ref_cnt_d = ref_cnt_q - RefW'(1);
        if (since_inc == MaxIbi) begin
          // Loss of signal: restart interval tracking and drop the threshold to its floor.
          timeout_d   = 1'b1;
          since_cnt_d = '0;
          have_prev_d = 1'b0;
          thr_d       = MinThr;
          decay_cnt_d = '0;
        end else begin
          since_cnt_d = since_inc;
          if (decay_inc == DecW'(DECAY_PERIOD)) begin
            decay_cnt_d = '0;
            thr_d       = (thr_dec > MinExt) ? thr_dec[WIDTH-1:0] : MinThr;
          end else begin
            decay_cnt_d = decay_inc;
          end
        end
      end
`ifdef PEAK_PLATEAU_EN
      if (detect || timeout_d) begin
        plat_d = 1'b0;
      end else if (plat_q) begin
        plat_d = (bus.ppg_in == prev_q);
      end else begin
        plat_d = (prev_q > prev2_q) && (prev_q == bus.ppg_in) && (prev_q > thr_q);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= '0;
      prev2_q      <= '0;
      thr_q        <= MinThr;
      peak_amp_q   <= '0;
      ref_cnt_q    <= '0;
      since_cnt_q  <= '0;
      ibi_q        <= '0;
      decay_cnt_q  <= '0;
      have_prev_q  <= 1'b0;
      peak_valid_q <= 1'b0;
      ibi_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef PEAK_PLATEAU_EN
      plat_q       <= 1'b0;
`endif
    end else begin
      prev_q       <= prev_d;
      prev2_q      <= prev2_d;
      thr_q        <= thr_d;
      peak_amp_q   <= peak_amp_d;
      ref_cnt_q    <= ref_cnt_d;
      since_cnt_q  <= since_cnt_d;
      ibi_q        <= ibi_d;
      decay_cnt_q  <= decay_cnt_d;
      have_prev_q  <= have_prev_d;
      peak_valid_q <= peak_valid_d;
      ibi_valid_q  <= ibi_valid_d;
      timeout_q    <= timeout_d;
`ifdef PEAK_PLATEAU_EN
      plat_q       <= plat_d;
`endif
    end
  end

  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_amp   = peak_amp_q;
  assign bus.ibi        = ibi_q;
  assign bus.ibi_valid  = ibi_valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.thr_out    = thr_q;

endmodule

// File: tb/tb_peak_detector_adaptive.sv
// Directed self-checking bench for peak_detector_adaptive with MAX_IBI shortened to 64.
module tb_peak_detector_adaptive;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_peak = 0;
  int   n_to = 0;
  int   min_thr;
  int   n0;

  always #5 clk = ~clk;

  peak_detector_adaptive_if #(.WIDTH(10), .IBI_WIDTH(12)) bus ();

  peak_detector_adaptive #(
    .WIDTH       (10),
    .MIN_THRESH  (20),
    .REF_PERIOD  (8),
    .DECAY_PERIOD(16),
    .DECAY_SHIFT (3),
    .IBI_WIDTH   (12),
    .MAX_IBI     (64)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One valid sample; outputs are sampled 1 time unit after the capturing edge.
  task automatic send(input int v);
    logic [31:0] w;
    w = v;
    bus.ppg_in   = w[9:0];
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    if (bus.peak_valid) n_peak++;
    if (bus.timeout) n_to++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.en       = 1'b1;
    bus.valid_in = 1'b0;
    bus.ppg_in   = '0;
    rst          = 1'b1;
    idle(2);
    rst = 1'b0;

    check("rst_pv", int'(bus.peak_valid), 0);
    check("rst_amp", int'($signed(bus.peak_amp)), 0);
    check("rst_ibi", int'(bus.ibi), 0);
    check("rst_iv", int'(bus.ibi_valid), 0);
    check("rst_to", int'(bus.timeout), 0);
    check("rst_thr", int'($signed(bus.thr_out)), 20);

    // First peak
    send(0); send(10); send(50);
    check("p1_early", n_peak, 0);
    send(30);
    check("p1_pv", int'(bus.peak_valid), 1);
    check("p1_amp", int'($signed(bus.peak_amp)), 50);
    check("p1_iv", int'(bus.ibi_valid), 0);
    check("p1_thr", int'($signed(bus.thr_out)), 22);
    idle(1);
    check("p1_pulse", int'(bus.peak_valid), 0);

    // Second peak 40 valid samples later, with gaps
    for (int k = 1; k <= 38; k++) begin
      send(0);
      if (k == 16) check("ibi_thr16", int'($signed(bus.thr_out)), 20);
      if (k == 32) check("ibi_thr32", int'($signed(bus.thr_out)), 20);
    end
    idle($urandom_range(1, 5));
    send(50);
    idle($urandom_range(1, 5));
    send(30);
    check("p2_pv", int'(bus.peak_valid), 1);
    check("p2_iv", int'(bus.ibi_valid), 1);
    check("p2_ibi", int'(bus.ibi), 40);
    check("p2_amp", int'($signed(bus.peak_amp)), 50);
    check("p2_thr", int'($signed(bus.thr_out)), 22);
    check("p2_cnt", n_peak, 2);

    // Refractory: 60 three samples after the 50
    send(45); send(60); send(10);
    check("ref_pv", int'(bus.peak_valid), 0);
    check("ref_thr", int'($signed(bus.thr_out)), 22);
    check("ref_amp", int'($signed(bus.peak_amp)), 50);
    check("ref_cnt", n_peak, 2);

    // Decay and timeout
    do_reset();
    send(0); send(100); send(400); send(0);
    check("dec_pv", int'(bus.peak_valid), 1);
    check("dec_thr0", int'($signed(bus.thr_out)), 110);
    min_thr = 511;
    for (int k = 1; k <= 64; k++) begin
      send(0);
      if (int'($signed(bus.thr_out)) < min_thr) min_thr = int'($signed(bus.thr_out));
      if (k == 15) check("dec_thr15", int'($signed(bus.thr_out)), 110);
      if (k == 16) check("dec_thr16", int'($signed(bus.thr_out)), 97);
      if (k == 48) check("dec_thr48", int'($signed(bus.thr_out)), 75);
      if (k == 63) check("to_early", n_to, 0);
      if (k == 64) begin
        check("to_pulse", int'(bus.timeout), 1);
        check("to_thr", int'($signed(bus.thr_out)), 20);
      end
    end
    check("thr_floor", int'(min_thr >= 20), 1);
    idle(1);
    check("to_clear", int'(bus.timeout), 0);
    send(100); send(0);
    check("post_to_pv", int'(bus.peak_valid), 1);
    check("post_to_iv", int'(bus.ibi_valid), 0);
    check("post_to_ibi", int'(bus.ibi), 0);
    check("post_to_thr", int'($signed(bus.thr_out)), 35);
    check("post_to_amp", int'($signed(bus.peak_amp)), 100);

    // Reset mid-rise; rst wins over a valid falling sample
    send(10); send(50);
    rst          = 1'b1;
    bus.ppg_in   = 10'sd30;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.valid_in = 1'b0;
    check("mr_pv", int'(bus.peak_valid), 0);
    check("mr_amp", int'($signed(bus.peak_amp)), 0);
    check("mr_thr", int'($signed(bus.thr_out)), 20);
    check("mr_ibi", int'(bus.ibi), 0);
    send(30);
    check("mr_after", int'(bus.peak_valid), 0);

    // Enable low during the falling sample freezes state
    send(40); send(50);
    n0 = n_peak;
    bus.en = 1'b0;
    send(30);
    idle(2);
    check("en_pv", n_peak - n0, 0);
    check("en_thr", int'($signed(bus.thr_out)), 20);
    check("en_amp", int'($signed(bus.peak_amp)), 0);
    bus.en = 1'b1;
    send(30);
    check("en_resume_pv", int'(bus.peak_valid), 1);
    check("en_resume_amp", int'($signed(bus.peak_amp)), 50);
    check("en_resume_thr", int'($signed(bus.thr_out)), 22);

    // Flat top
    do_reset();
    n0 = n_peak;
    send(10); send(50); send(50); send(50); send(30);
    idle(1);
`ifdef PEAK_PLATEAU_EN
    check("plat_cnt", n_peak - n0, 1);
    check("plat_amp", int'($signed(bus.peak_amp)), 50);
`else
    check("plat_cnt", n_peak - n0, 0);
    check("plat_amp", int'($signed(bus.peak_amp)), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/peak_detector_adaptive.md
Name: peak_detector_adaptive

Overview:
Second-generation PPG peak detector, downstream of the PreProcessing DownSampler.
- Replaces the fixed threshold with an adaptive amplitude threshold that decays over time.
- Reports peak amplitude and inter-beat interval (IBI) in valid-sample units.
- Flags loss of signal when no peak arrives within MAX_IBI samples; feeds the heart-rate estimator.

Parameters:
WIDTH, 10, signed sample width
MIN_THRESH, 20, threshold floor and threshold value after reset/timeout (positive, < 2^(WIDTH-1))
REF_PERIOD, 8, refractory length in valid samples after a detected peak
DECAY_PERIOD, 16, valid samples without a peak between threshold decay steps
DECAY_SHIFT, 3, decay step = thr >>> DECAY_SHIFT
IBI_WIDTH, 12, IBI output width
MAX_IBI, 2047, timeout in valid samples (must be < 2^IBI_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  enable; low = hold all state, clear pulses
ppg_in  in  WIDTH signed  sample
valid_in  in  1  sample strobe
peak_valid  out  1  one-clock pulse: peak detected
peak_amp  out  WIDTH signed  amplitude of last detected peak, held
ibi  out  IBI_WIDTH  last interval between consecutive peaks, held
ibi_valid  out  1  one-clock pulse with peak_valid when ibi is fresh
timeout  out  1  one-clock pulse: MAX_IBI samples with no peak
thr_out  out  WIDTH signed  current threshold (debug)

Behaviour:
- Reset (rst=1 at clk edge): prev, prev2 = 0; ref_cnt = 0; since_cnt = 0; decay_cnt = 0; thr = MIN_THRESH; have_prev = 0. Outputs: peak_valid, ibi_valid, timeout = 0; peak_amp = 0; ibi = 0.
- Reset mid-operation discards any pending peak or interval; rst wins over en.
- en=0: pulses cleared next clock; all other state holds; valid_in ignored.
- Pulses default to 0 every clock. All state updates only on clocks with en=1 and valid_in=1.
- Detect condition: ref_cnt==0 AND prev>prev2 AND prev>ppg_in AND prev>thr, all signed compares. The peak sample is prev.
- Latency: peak_valid asserts the clock after the valid_in carrying the first falling sample.
- On detect:
  - peak_valid=1; peak_amp<=prev; ref_cnt<=REF_PERIOD; decay_cnt<=0; since_cnt<=0.
  - If have_prev: ibi<=since_cnt+1 and ibi_valid=1. have_prev<=1.
  - thr <= max(MIN_THRESH, (thr>>>1)+(prev>>>2)), computed in WIDTH+1 bits; the result always fits WIDTH.
- Otherwise:
  - ref_cnt decrements if >0.
  - since_cnt increments.
  - decay_cnt increments. When it reaches DECAY_PERIOD: thr <= max(MIN_THRESH, thr-(thr>>>DECAY_SHIFT)) and decay_cnt<=0.
- Timeout (no detect, since_cnt+1==MAX_IBI):
  - timeout=1; since_cnt<=0; have_prev<=0; thr<=MIN_THRESH; decay_cnt<=0.
  - Timeout overrides a decay step on the same sample.
- Detect and timeout on the same sample: detect wins, no timeout.
- History shift every valid sample: prev2<=prev; prev<=ppg_in.
- thr_out = thr register.

Optional Feature:
Macro PEAK_PLATEAU_EN.
- Defined:
  - Flat tops are accepted. If prev>prev2, prev==ppg_in and prev>thr, a plateau flag is set and the rising edge is remembered.
  - While the flag is set, equal samples keep it. The peak is declared when a sample falls below the plateau value, with the same side effects as a normal detect; peak_amp = plateau value.
  - A rising sample clears the flag.
  - The refractory and threshold rules are unchanged.
- Undefined: strict compares only; a plateau top never detects.

Test Plan:
(Bench params: MIN_THRESH=20, REF_PERIOD=8, DECAY_PERIOD=16, DECAY_SHIFT=3, MAX_IBI=64.)
- First peak: reset, samples 0,10,50,30 -> peak_valid one clock after the 30; peak_amp=50; ibi_valid=0; thr_out=22.
- IBI: a second peak of 50 placed 40 valid samples after the first, the peak fed with valid_in gaps of random length -> ibi=40, ibi_valid=1 with peak_valid.
- Refractory: peak 50 then peak 60 three samples later -> second peak not reported; thr unchanged by it.
- Decay: peak 400 (thr 20->110), then 16 flat samples of 0 -> thr_out=97. Continued flat input -> thr never below 20.
- Timeout: after a peak, 64 valid samples with no peak -> timeout pulse; thr_out=20. Next peak -> ibi_valid=0.
- Reset/enable: rst asserted mid-rise, and en low during the falling sample -> no peak_valid. All outputs at reset values. State frozen while en=0. With PEAK_PLATEAU_EN, samples 10,50,50,50,30 -> one peak, amp 50.
